// File: rtl/wishbone_burst_master_pkg.sv
// Shared definitions for the Wishbone burst master: FSM encoding, default
// ack timeout and the MachXO2 EFB register map used by PMIC callers.
package wishbone_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

    // EFB primary I2C, SPI and timer/counter register addresses
    localparam logic [7:0] EFB_I2C1_CR   = 8'h40;
    localparam logic [7:0] EFB_I2C1_CMDR = 8'h41;
    localparam logic [7:0] EFB_I2C1_BR0  = 8'h42;
    localparam logic [7:0] EFB_I2C1_BR1  = 8'h43;
    localparam logic [7:0] EFB_I2C1_TXDR = 8'h44;
    localparam logic [7:0] EFB_I2C1_SR   = 8'h45;
    localparam logic [7:0] EFB_I2C1_RXDR = 8'h47;
    localparam logic [7:0] EFB_SPI_CR0   = 8'h54;
    localparam logic [7:0] EFB_TC_CR0    = 8'h5E;

endpackage

// File: rtl/wb_ack_timeout.sv
// Per-beat acknowledge watchdog: loadable down-counter whose expire flag
// rises in the TIMEOUT_CYC-th enabled cycle after a load.
module wb_ack_timeout #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_VAL;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired_c = i_en && (cnt_q == '0);

endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone classic master issuing single or burst reads/writes with optional
// address increment and a per-beat ack timeout that aborts with o_error.
module wishbone_burst_master
    import wishbone_burst_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_begin,
    input  logic              i_writeEnable,
    input  logic              i_incAddr,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LEN_W-1:0]  i_length,
    input  logic [DATA_W-1:0] i_writeData,
    output logic              o_beatAck,
    output logic [DATA_W-1:0] o_readData,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [DATA_W-1:0] o_wb_dat,
    input  logic [DATA_W-1:0] i_wb_dat,
    input  logic              i_wb_ack
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              inc_q, inc_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              ack_c;
    logic              load_c;
    logic              timeout_c;

    assign ack_c  = (state_q == ST_STROBE) && i_wb_ack;
    assign load_c = (state_d == ST_STROBE) && (state_q != ST_STROBE);

    generate
        if (TIMEOUT_CYC != 0) begin : g_timeout
            wb_ack_timeout #(
                .TIMEOUT_CYC(TIMEOUT_CYC)
            ) u_ack_timeout (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_load     (load_c),
                .i_en       (state_q == ST_STROBE),
                .o_expired_c(timeout_c)
            );
        end else begin : g_no_timeout
            assign timeout_c = 1'b0;
        end
    endgenerate

    // Next-state and datapath; bus controls are registered from the next state
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        inc_d      = inc_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (i_begin) begin
                    state_d    = ST_STROBE;
                    beat_cnt_d = i_length;
                    adr_d      = i_address;
                    we_d       = i_writeEnable;
                    inc_d      = i_incAddr;
                    dat_d      = i_writeData;
                    error_d    = 1'b0;
                end
            end
            ST_STROBE: begin
                if (i_wb_ack) begin
                    if (!we_q) begin
                        rdata_d = i_wb_dat;
                    end
                    state_d = (beat_cnt_q == '0) ? ST_DONE : ST_GAP;
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                beat_cnt_d = beat_cnt_q - LEN_W'(1);
                if (inc_q) begin
                    adr_d = adr_q + ADDR_W'(1);
                end
                dat_d   = i_writeData;
                state_d = ST_STROBE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cyc_d  = (state_d == ST_STROBE) || (state_d == ST_GAP);
        stb_d  = (state_d == ST_STROBE);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            inc_q      <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            inc_q      <= inc_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Beat ack and read data track the slave ack in the same cycle
    assign o_beatAck  = ack_c;
    assign o_readData = (ack_c && !we_q) ? i_wb_dat : rdata_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_error    = error_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Randomized self-checking bench for wishbone_burst_master; a beat-level
// slave/reference model predicts every bus and handshake output per cycle.
module tb_wishbone_burst_master;

    localparam int unsigned TB_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_begin;
    logic       we_in;
    logic       inc_in;
    logic [7:0] addr_in;
    logic [3:0] len_in;
    logic [7:0] wdata_in;
    logic       beat_ack;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       error;
    logic       wb_cyc;
    logic       wb_stb;
    logic       wb_we;
    logic [7:0] wb_adr;
    logic [7:0] wb_dat;
    logic [7:0] wb_dat_in;
    logic       wb_ack;

    int         errors = 0;
    int         checks = 0;
    logic       exp_error;
    logic [7:0] exp_rdata;
    logic [7:0] wdata_a [16];
    logic [7:0] rdata_a [16];
    int         wait_a  [16];

    always #5 clk = ~clk;

    wishbone_burst_master #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .LEN_W      (4),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_begin      (i_begin),
        .i_writeEnable(we_in),
        .i_incAddr    (inc_in),
        .i_address    (addr_in),
        .i_length     (len_in),
        .i_writeData  (wdata_in),
        .o_beatAck    (beat_ack),
        .o_readData   (rdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_wb_cyc     (wb_cyc),
        .o_wb_stb     (wb_stb),
        .o_wb_we      (wb_we),
        .o_wb_adr     (wb_adr),
        .o_wb_dat     (wb_dat),
        .i_wb_dat     (wb_dat_in),
        .i_wb_ack     (wb_ack)
    );

    // Drive one whole burst as slave and predict each cycle from beat rules:
    // beat k waits wait_a[k] cycles; waits >= TB_TIMEOUT never ack and abort.
    task automatic run_burst(input string name, input logic we, input logic inc,
                             input logic [7:0] addr, input logic [3:0] len);
        logic [7:0] exp_adr;
        logic [4:0] ctrl;
        logic [4:0] exp_ctrl;
        int         ncyc;
        bit         aborted;
        bit         ack;
        aborted = 0;
        @(negedge clk);
        i_begin = 1'b1; we_in = we; inc_in = inc; addr_in = addr; len_in = len;
        wdata_in = wdata_a[0]; wb_ack = 1'b0;
        @(negedge clk);
        exp_error = 1'b0;
        for (int k = 0; k <= int'(len) && !aborted; k++) begin
            exp_adr = inc ? addr + 8'(k) : addr;
            ncyc = (wait_a[k] < int'(TB_TIMEOUT)) ? wait_a[k] + 1 : int'(TB_TIMEOUT);
            for (int c = 0; c < ncyc; c++) begin
                ctrl = {wb_cyc, wb_stb, busy, done, error};
                exp_ctrl = {4'b1110, exp_error};
                checks++;
                if (ctrl !== exp_ctrl) begin
                    errors++;
                    $display("FAIL %s strobe ctrl beat %0d cyc %0d: got %b want %b", name, k, c, ctrl, exp_ctrl);
                end
                checks++;
                if (wb_adr !== exp_adr || wb_we !== we) begin
                    errors++;
                    $display("FAIL %s adr/we beat %0d: got %h/%b want %h/%b", name, k, wb_adr, wb_we, exp_adr, we);
                end
                if (we) begin
                    checks++;
                    if (wb_dat !== wdata_a[k]) begin
                        errors++;
                        $display("FAIL %s wdat beat %0d: got %h want %h", name, k, wb_dat, wdata_a[k]);
                    end
                end
                ack = (c == wait_a[k]);
                wb_ack = ack;
                wb_dat_in = ack ? rdata_a[k] : 8'($urandom);
                i_begin = 1'($urandom);
                we_in = 1'($urandom); addr_in = 8'($urandom); len_in = 4'($urandom);
                wdata_in = 8'($urandom);
                #1;
                if (ack && !we) exp_rdata = rdata_a[k];
                checks++;
                if (beat_ack !== ack || rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s beatAck/rdata beat %0d: got %b/%h want %b/%h", name, k, beat_ack, rdata, ack, exp_rdata);
                end
                @(negedge clk);
            end
            if (wait_a[k] >= int'(TB_TIMEOUT)) begin
                aborted = 1;
                exp_error = 1'b1;
            end else if (k < int'(len)) begin
                ctrl = {wb_cyc, wb_stb, busy, done, error};
                exp_ctrl = {4'b1010, exp_error};
                checks++;
                if (ctrl !== exp_ctrl) begin
                    errors++;
                    $display("FAIL %s gap ctrl after beat %0d: got %b want %b", name, k, ctrl, exp_ctrl);
                end
                wdata_in = wdata_a[k+1];
                wb_ack = 1'($urandom); wb_dat_in = 8'($urandom); i_begin = 1'($urandom);
                #1;
                checks++;
                if (beat_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap beatAck: got %b want 0", name, beat_ack);
                end
                @(negedge clk);
            end
        end
        ctrl = {wb_cyc, wb_stb, busy, done, error};
        exp_ctrl = {4'b0011, exp_error};
        checks++;
        if (ctrl !== exp_ctrl) begin
            errors++;
            $display("FAIL %s done ctrl: got %b want %b", name, ctrl, exp_ctrl);
        end
        wb_ack = 1'($urandom); i_begin = 1'($urandom);
        #1;
        checks++;
        if (beat_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s done beatAck: got %b want 0", name, beat_ack);
        end
        @(negedge clk);
        i_begin = 1'b0; wb_ack = 1'b0;
        ctrl = {wb_cyc, wb_stb, busy, done, error};
        exp_ctrl = {4'b0000, exp_error};
        #1;
        checks++;
        if (ctrl !== exp_ctrl || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s idle ctrl/rdata: got %b/%h want %b/%h", name, ctrl, rdata, exp_ctrl, exp_rdata);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            wdata_a[i] = 8'($urandom);
            rdata_a[i] = 8'($urandom);
            wait_a[i]  = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({beat_ack, rdata, busy, done, error, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat} !== 31'd0) begin
            errors++;
            $display("FAIL reset outputs: got %b want all 0",
                     {beat_ack, rdata, busy, done, error, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat});
        end
        rst_n = 1'b1;
        exp_error = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
        checks++;
        if ({wb_cyc, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL post-reset idle: got %b want 000", {wb_cyc, busy, done});
        end
    endtask

    task automatic test_single_write();
        clear_tables();
        wdata_a[0] = 8'h34;
        run_burst("single_write", 1'b1, 1'b0, 8'h12, 4'd0);
    endtask

    task automatic test_read_burst();
        clear_tables();
        for (int i = 0; i < 4; i++) begin
            rdata_a[i] = 8'hA0 + 8'(i);
            wait_a[i] = 2;
        end
        run_burst("read_burst", 1'b0, 1'b1, 8'h40, 4'd3);
    endtask

    task automatic test_fixed_write();
        clear_tables();
        wdata_a[0] = 8'h11; wdata_a[1] = 8'h22; wdata_a[2] = 8'h33;
        run_burst("fixed_write", 1'b1, 1'b0, 8'h0D, 4'd2);
    endtask

    task automatic test_addr_wrap();
        clear_tables();
        run_burst("addr_wrap", 1'b0, 1'b1, 8'hFE, 4'd2);
    endtask

    task automatic test_timeout();
        clear_tables();
        wait_a[0] = 1000;
        run_burst("timeout", 1'b0, 1'b1, 8'h33, 4'd1);
        clear_tables();
        wait_a[0] = 1;
        run_burst("after_timeout", 1'b1, 1'b0, 8'h45, 4'd0);
        clear_tables();
        wait_a[1] = int'(TB_TIMEOUT) - 1;
        wait_a[2] = int'(TB_TIMEOUT);
        run_burst("late_beat_timeout", 1'b1, 1'b1, 8'h50, 4'd3);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        i_begin = 1'b1; we_in = 1'b1; inc_in = 1'b1; addr_in = 8'h77;
        len_in = 4'd5; wdata_in = 8'h5A; wb_ack = 1'b0;
        @(negedge clk);
        i_begin = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, busy} !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid pre: got %b want 111", {wb_cyc, wb_stb, busy});
        end
        rst_n = 1'b0;
        wb_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({beat_ack, rdata, busy, done, error, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat} !== 31'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b want all 0",
                     {beat_ack, rdata, busy, done, error, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat});
        end
        wb_ack = 1'b0;
        rst_n = 1'b1;
        exp_error = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
        checks++;
        if ({done, busy, wb_cyc} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid no done: got %b want 000", {done, busy, wb_cyc});
        end
        clear_tables();
        run_burst("after_reset", 1'b0, 1'b0, 8'h20, 4'd1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            clear_tables();
            for (int i = 0; i < 16; i++) begin
                wait_a[i] = int'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) wait_a[i] = int'(TB_TIMEOUT) + int'($urandom_range(0, 2));
            end
            run_burst("random", 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        clear_tables();
        run_burst("b2b_first", 1'b1, 1'b1, 8'hF0, 4'd1);
        clear_tables();
        wait_a[0] = 3;
        run_burst("b2b_second", 1'b0, 1'b1, 8'hFF, 4'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_begin = 1'b0; we_in = 1'b0; inc_in = 1'b0;
        addr_in = 8'h00; len_in = 4'd0; wdata_in = 8'h00;
        wb_dat_in = 8'h00; wb_ack = 1'b0;
        exp_error = 1'b0; exp_rdata = 8'h00;
        test_reset();
        test_single_write();
        test_read_burst();
        test_fixed_write();
        test_addr_wrap();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
